// File: rtl/layer_ram_controller_pkg.sv
// Shared definitions for the layer evaluation blocks: sequencer state encoding,
// fixed-point defaults and the output saturation / activation helpers.
package layer_ram_controller_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FRAC_DEF   = 4;
    localparam int ACC_W_DEF  = 20;
    localparam int WIDE_W     = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAST  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [WIDE_W-1:0] sat_signed(
        input logic signed [WIDE_W-1:0] v,
        input int unsigned              w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [WIDE_W-1:0] relu(
        input logic signed [WIDE_W-1:0] v,
        input logic                     en
    );
        if (en && (v < 0)) begin
            return '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/layer_ram_controller_mac_unit.sv
// Signed multiply-accumulate with clear, plus the fixed-point rescale,
// saturation and optional ReLU applied to the accumulator for write-back.
module mac_unit
    import layer_ram_controller_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     relu_en,
    output logic signed [DATA_W-1:0] y_out
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_shift;
    logic signed [WIDE_W-1:0]   acc_wide;
    logic signed [WIDE_W-1:0]   sat_v;
    logic signed [WIDE_W-1:0]   act_v;

    always_comb begin
        prod  = w_in * x_in;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Arithmetic shift floors toward -inf, matching the fixed-point format.
    always_comb begin
        acc_shift = acc_q >>> FRAC;
        acc_wide  = WIDE_W'(acc_shift);
        sat_v     = sat_signed(acc_wide, DATA_W);
        act_v     = relu(sat_v, relu_en);
        y_out     = DATA_W'(act_v);
    end

endmodule

// File: rtl/layer_ram_controller.sv
// Slave sequencer evaluating one network layer: streams weights and inputs
// from synchronous RAMs into a MAC, writes one activated output per neuron.
module layer_ram_controller
    import layer_ram_controller_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC      = FRAC_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int ADDR_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   layer,
    input  logic                         layer_sel,
    output logic                         done,
    output logic [ADDR_W-1:0]            w_addr,
    input  logic [DATA_W-1:0]            w_data,
    output logic [$clog2(N_INPUTS)-1:0]  x_addr,
    input  logic [DATA_W-1:0]            x_data,
    output logic                         y_we,
    output logic [$clog2(N_NEURONS)-1:0] y_addr,
    output logic [DATA_W-1:0]            y_data
);

    localparam int XW = $clog2(N_INPUTS);
    localparam int YW = $clog2(N_NEURONS);

    state_e                   state_q;
    state_e                   state_d;
    logic [1:0]               layer_q;
    logic [1:0]               layer_d;
    logic                     sel_q;
    logic                     sel_d;
    logic [YW-1:0]            neuron_q;
    logic [YW-1:0]            neuron_d;
    logic [XW-1:0]            i_q;
    logic [XW-1:0]            i_d;
    logic                     rd_valid_q;
    logic                     rd_valid_d;
    logic                     acc_clear;
    logic signed [DATA_W-1:0] mac_y;

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        sel_d      = sel_q;
        neuron_d   = neuron_q;
        i_d        = i_q;
        rd_valid_d = 1'b0;
        acc_clear  = 1'b0;
        done       = 1'b0;
        y_we       = 1'b0;
        y_addr     = '0;
        y_data     = '0;
        w_addr     = '0;
        x_addr     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    layer_d   = layer;
                    sel_d     = layer_sel;
                    neuron_d  = '0;
                    i_d       = '0;
                    acc_clear = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Data for this address returns next cycle, hence rd_valid lags by one.
                w_addr     = ADDR_W'(int'(layer_q) * N_NEURONS * N_INPUTS
                                     + int'(neuron_q) * N_INPUTS + int'(i_q));
                x_addr     = i_q;
                rd_valid_d = 1'b1;
                if (i_q == XW'(N_INPUTS - 1)) begin
                    i_d     = '0;
                    state_d = ST_LAST;
                end else begin
                    i_d = i_q + XW'(1);
                end
            end
            ST_LAST: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                y_we      = 1'b1;
                y_addr    = neuron_q;
                y_data    = mac_y;
                acc_clear = 1'b1;
                i_d       = '0;
                if (neuron_q == YW'(N_NEURONS - 1)) begin
                    neuron_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    neuron_d = neuron_q + YW'(1);
                    state_d  = ST_RUN;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            layer_q    <= '0;
            sel_q      <= 1'b0;
            neuron_q   <= '0;
            i_q        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            sel_q      <= sel_d;
            neuron_q   <= neuron_d;
            i_q        <= i_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .acc_en  (rd_valid_q),
        .w_in    (w_data),
        .x_in    (x_data),
        .relu_en (sel_q),
        .y_out   (mac_y)
    );

endmodule

// File: tb/tb_layer_ram_controller.sv
// Randomized bench for layer_ram_controller: a transaction-level model predicts
// per-cycle addresses, writes and done; literal cases pin the model itself.
module tb_layer_ram_controller;

    localparam int NN      = 4;
    localparam int NI      = 4;
    localparam int DW      = 8;
    localparam int AW      = 8;
    localparam int FRAC    = 4;
    localparam int P       = NI + 2;
    localparam int RUN_LEN = NN * P;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    layer = '0;
    logic          layer_sel = 1'b0;
    logic          done;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data = '0;
    logic [1:0]    x_addr;
    logic [DW-1:0] x_data = '0;
    logic          y_we;
    logic [1:0]    y_addr;
    logic [DW-1:0] y_data;

    int wmem [256];
    int xmem [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_phase = -1;
    int m_layer = 0;
    int m_y [NN];

    int dut_writes = 0;
    int dut_dones  = 0;
    int done_cyc   = 0;
    int start_cyc  = 0;
    int first_wa   = -1;
    int last_wa    = -1;
    int got_y [NN];

    layer_ram_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .layer     (layer),
        .layer_sel (layer_sel),
        .done      (done),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .y_we      (y_we),
        .y_addr    (y_addr),
        .y_data    (y_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous RAM / buffer models: one cycle read latency.
    always @(posedge clk) begin
        w_data <= DW'(wmem[w_addr]);
        x_data <= DW'(xmem[x_addr]);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_neuron(input int lay, input int sel, input int n);
        int acc;
        int v;
        acc = 0;
        for (int i = 0; i < NI; i++) begin
            acc += wmem[(lay * NN * NI + n * NI + i) % 256] * xmem[i];
        end
        v = acc >>> FRAC;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        if (sel != 0 && v < 0) v = 0;
        return v;
    endfunction

    // Transaction model: m_phase counts edges since the accepting edge, -1 when idle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = -1;
        end else if (m_phase == -1) begin
            if (start) begin
                m_layer = int'(layer);
                for (int n = 0; n < NN; n++) m_y[n] = model_neuron(int'(layer), int'(layer_sel), n);
                m_phase = 0;
            end
        end else if (m_phase == RUN_LEN) begin
            m_phase = -1;
        end else begin
            m_phase++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            int  ph;
            logic exp_we;
            ph     = m_phase;
            exp_we = (ph >= 0) && (ph < RUN_LEN) && ((ph % P) == P - 1);
            check("done", int'(done), int'(ph == RUN_LEN));
            check("y_we", int'(y_we), int'(exp_we));
            if (exp_we) begin
                check("y_addr", int'(y_addr), ph / P);
                check("y_data", int'($signed(y_data)), m_y[ph / P]);
            end
            if ((ph >= 0) && (ph < RUN_LEN) && ((ph % P) < NI)) begin
                check("w_addr", int'(w_addr),
                      (m_layer * NN * NI + (ph / P) * NI + (ph % P)) % 256);
                check("x_addr", int'(x_addr), ph % P);
                if (ph == 0) first_wa = int'(w_addr);
                last_wa = int'(w_addr);
            end
            if (ph == 0) begin
                for (int n = 0; n < NN; n++) got_y[n] = -999;
            end
            if (y_we) begin
                got_y[y_addr] = int'($signed(y_data));
                dut_writes++;
            end
            if (done) begin
                dut_dones++;
                done_cyc = cyc;
            end
        end
    end

    task automatic fill_w(input int v);
        for (int a = 0; a < 256; a++) wmem[a] = v;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) wmem[a] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NI; i++) xmem[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic pulse_start(input int lay, input int sel);
        @(negedge clk);
        layer     = 2'(lay);
        layer_sel = sel[0];
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        d0 = dut_dones;
        for (int k = 0; k < 100 && dut_dones == d0; k++) @(negedge clk);
        check("done_within_budget", dut_dones - d0, 1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int w0;
        fill_w(0);
        for (int i = 0; i < NI; i++) xmem[i] = 0;

        repeat (2) @(negedge clk);
        check("rst_done", int'(done), 0);
        check("rst_y_we", int'(y_we), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_x_addr", int'(x_addr), 0);
        check("rst_y_addr", int'(y_addr), 0);
        check("rst_y_data", int'(y_data), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Identity layer, ReLU.
        fill_w(0);
        for (int n = 0; n < NN; n++) wmem[n * NI + n] = 16;
        for (int i = 0; i < NI; i++) xmem[i] = 10 * (i + 1);
        pulse_start(0, 1);
        wait_done();
        for (int n = 0; n < NN; n++) check("identity_y", got_y[n], 10 * (n + 1));
        check("identity_latency", done_cyc - start_cyc, 25);

        // Negative sums: ReLU clamps to zero, linear passes -64.
        fill_w(-16);
        for (int i = 0; i < NI; i++) xmem[i] = 16;
        pulse_start(0, 1);
        wait_done();
        for (int n = 0; n < NN; n++) check("relu_y", got_y[n], 0);
        pulse_start(2, 0);
        wait_done();
        for (int n = 0; n < NN; n++) check("linear_y", got_y[n], -64);

        // Saturation at both rails.
        fill_w(127);
        for (int i = 0; i < NI; i++) xmem[i] = 127;
        pulse_start(1, 1);
        wait_done();
        for (int n = 0; n < NN; n++) check("sat_hi_y", got_y[n], 127);
        fill_w(-128);
        pulse_start(1, 0);
        wait_done();
        for (int n = 0; n < NN; n++) check("sat_lo_y", got_y[n], -128);

        // Top layer addressing.
        fill_random();
        pulse_start(3, 0);
        wait_done();
        check("layer3_first_waddr", first_wa, 48);
        check("layer3_last_waddr", last_wa, 63);

        // Stray starts and input changes mid-run are ignored.
        fill_random();
        d0 = dut_dones;
        w0 = dut_writes;
        pulse_start(1, 1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 3 || k == 8) begin
                start     = 1'b1;
                layer     = 2'($urandom_range(0, 3));
                layer_sel = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        check("midrun_writes", dut_writes - w0, 4);
        check("midrun_dones", dut_dones - d0, 1);

        // Async reset mid-run aborts immediately.
        fill_random();
        pulse_start(2, 1);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_y_we", int'(y_we), 0);
        check("abort_done", int'(done), 0);
        check("abort_w_addr", int'(w_addr), 0);
        check("abort_x_addr", int'(x_addr), 0);
        check("abort_y_data", int'(y_data), 0);
        @(negedge clk);
        reset = 1'b0;
        d0 = dut_dones;
        repeat (30) @(negedge clk);
        check("abort_no_done", dut_dones - d0, 0);
        pulse_start(0, 0);
        wait_done();
        check("post_abort_latency", done_cyc - start_cyc, 25);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            fill_random();
            pulse_start(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            wait_done();
        end

        // start held high across the end of a run begins exactly one new run.
        fill_random();
        d0 = dut_dones;
        w0 = dut_writes;
        @(negedge clk);
        layer     = 2'd1;
        layer_sel = 1'b0;
        start     = 1'b1;
        repeat (35) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("held_start_dones", dut_dones - d0, 2);
        check("held_start_writes", dut_writes - w0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
